// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings and helpers for the pipeline hazard controller
package hazard_ctrl_pkg;

    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] WAIT       = 2'd1;
    localparam logic [1:0] FLUSH_PEND = 2'd2;

    localparam logic [1:0] FWD_RD  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // $zero is hardwired, so a write to it never produces a value worth matching
    function automatic logic reg_hit(input logic en, input logic [4:0] dst, input logic [4:0] src);
        return en && (dst != REG_ZERO) && (dst == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side bundle of hazard inputs and stall/flush/forward controls
interface hazard_ctrl_if #(parameter int CNT_W = 16);
    logic [4:0]       ID_Rs;
    logic [4:0]       ID_Rt;
    logic             ID_UsesRt;
    logic [4:0]       EX_Rs;
    logic [4:0]       EX_Rt;
    logic             EX_MemtoReg;
    logic [4:0]       EX_WriteReg;
    logic             MEM_RegWrite;
    logic [4:0]       MEM_WriteReg;
    logic             WB_RegWrite;
    logic [4:0]       WB_WriteReg;
    logic             PCSrcM;
    logic             MemWait;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic [1:0]       State;
    logic [CNT_W-1:0] StallCnt;
    logic [CNT_W-1:0] FlushCnt;
    logic [CNT_W-1:0] WaitCnt;

    modport master (
        output ID_Rs, ID_Rt, ID_UsesRt, EX_Rs, EX_Rt, EX_MemtoReg, EX_WriteReg,
               MEM_RegWrite, MEM_WriteReg, WB_RegWrite, WB_WriteReg, PCSrcM, MemWait,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM,
               ForwardAE, ForwardBE, State, StallCnt, FlushCnt, WaitCnt
    );

    modport slave (
        input  ID_Rs, ID_Rt, ID_UsesRt, EX_Rs, EX_Rt, EX_MemtoReg, EX_WriteReg,
               MEM_RegWrite, MEM_WriteReg, WB_RegWrite, WB_WriteReg, PCSrcM, MemWait,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushM,
               ForwardAE, ForwardBE, State, StallCnt, FlushCnt, WaitCnt
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// rtl/hazard_ctrl_sat_counter.sv - saturating event counter, holds at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forward sequencing for the 5-stage MIPS pipeline
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input logic          CLK,
    input logic          RST,
    hazard_ctrl_if.slave hz
);
    import hazard_ctrl_pkg::*;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             lu;
    logic             stall_all;
    logic             stall_fd;
    logic             flush_all;
    logic             bubble;
    logic             inc_stall;
    logic             inc_flush;
    logic             inc_wait;
    logic             illegal;
    logic             quiet;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] wait_cnt;

    always_comb begin
        lu = hz.EX_MemtoReg &&
             (reg_hit(1'b1, hz.EX_WriteReg, hz.ID_Rs) ||
              reg_hit(hz.ID_UsesRt, hz.EX_WriteReg, hz.ID_Rt));
    end

    // WAIT behaves as RUN for the cycle MemWait drops, so both share one decode
    always_comb begin
        stall_all = 1'b0;
        stall_fd  = 1'b0;
        flush_all = 1'b0;
        bubble    = 1'b0;
        inc_stall = 1'b0;
        inc_flush = 1'b0;
        inc_wait  = 1'b0;
        illegal   = 1'b0;
        state_nxt = RUN;
        case (state)
            RUN, WAIT: begin
                if (hz.MemWait) begin
                    stall_all = 1'b1;
                    inc_wait  = 1'b1;
                    state_nxt = hz.PCSrcM ? FLUSH_PEND : WAIT;
                end else if (hz.PCSrcM) begin
                    flush_all = 1'b1;
                    inc_flush = 1'b1;
                end else if (lu) begin
                    stall_fd  = 1'b1;
                    bubble    = 1'b1;
                    inc_stall = 1'b1;
                end
            end
            FLUSH_PEND: begin
                if (hz.MemWait) begin
                    stall_all = 1'b1;
                    inc_wait  = 1'b1;
                    state_nxt = FLUSH_PEND;
                end else begin
                    flush_all = 1'b1;
                    inc_flush = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    assign quiet = RST || illegal;

    always_comb begin
        fwd_a = FWD_RD;
        if (reg_hit(hz.MEM_RegWrite, hz.MEM_WriteReg, hz.EX_Rs)) begin
            fwd_a = FWD_MEM;
        end else if (reg_hit(hz.WB_RegWrite, hz.WB_WriteReg, hz.EX_Rs)) begin
            fwd_a = FWD_WB;
        end
        fwd_b = FWD_RD;
        if (reg_hit(hz.MEM_RegWrite, hz.MEM_WriteReg, hz.EX_Rt)) begin
            fwd_b = FWD_MEM;
        end else if (reg_hit(hz.WB_RegWrite, hz.WB_WriteReg, hz.EX_Rt)) begin
            fwd_b = FWD_WB;
        end
    end

    assign hz.ForwardAE = quiet ? FWD_RD : fwd_a;
    assign hz.ForwardBE = quiet ? FWD_RD : fwd_b;

    assign hz.StallF = !quiet && (stall_all || stall_fd);
    assign hz.StallD = !quiet && (stall_all || stall_fd);
    assign hz.StallE = !quiet && stall_all;
    assign hz.StallM = !quiet && stall_all;
    assign hz.FlushD = !quiet && flush_all;
    assign hz.FlushE = !quiet && (flush_all || bubble);
    assign hz.FlushM = !quiet && flush_all;
    assign hz.State  = state;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (inc_stall),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (inc_flush),
        .count (flush_cnt)
    );

    sat_counter #(.W(CNT_W)) u_wait_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (inc_wait),
        .count (wait_cnt)
    );

    assign hz.StallCnt = stall_cnt;
    assign hz.FlushCnt = flush_cnt;
    assign hz.WaitCnt  = wait_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl against a behavioural model
module tb_hazard_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic [4:0] id_rs = 0, id_rt = 0, ex_rs = 0, ex_rt = 0, ex_wr = 0, mem_wr = 0, wb_wr = 0;
    logic       id_uses_rt = 0, ex_m2r = 0, mem_rw = 0, wb_rw = 0, pcsrc = 0, memwait = 0;

    hazard_ctrl_if #(.CNT_W(16)) hz ();
    hazard_ctrl_if #(.CNT_W(2))  hz2 ();

    assign hz.ID_Rs = id_rs;          assign hz2.ID_Rs = id_rs;
    assign hz.ID_Rt = id_rt;          assign hz2.ID_Rt = id_rt;
    assign hz.ID_UsesRt = id_uses_rt; assign hz2.ID_UsesRt = id_uses_rt;
    assign hz.EX_Rs = ex_rs;          assign hz2.EX_Rs = ex_rs;
    assign hz.EX_Rt = ex_rt;          assign hz2.EX_Rt = ex_rt;
    assign hz.EX_MemtoReg = ex_m2r;   assign hz2.EX_MemtoReg = ex_m2r;
    assign hz.EX_WriteReg = ex_wr;    assign hz2.EX_WriteReg = ex_wr;
    assign hz.MEM_RegWrite = mem_rw;  assign hz2.MEM_RegWrite = mem_rw;
    assign hz.MEM_WriteReg = mem_wr;  assign hz2.MEM_WriteReg = mem_wr;
    assign hz.WB_RegWrite = wb_rw;    assign hz2.WB_RegWrite = wb_rw;
    assign hz.WB_WriteReg = wb_wr;    assign hz2.WB_WriteReg = wb_wr;
    assign hz.PCSrcM = pcsrc;         assign hz2.PCSrcM = pcsrc;
    assign hz.MemWait = memwait;      assign hz2.MemWait = memwait;

    hazard_ctrl #(.CNT_W(16)) dut  (.CLK(CLK), .RST(RST), .hz(hz.slave));
    hazard_ctrl #(.CNT_W(2))  dut2 (.CLK(CLK), .RST(RST), .hz(hz2.slave));

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: a branch is remembered while memory is busy and released once it frees up
    bit m_pending = 0;
    bit m_frozen  = 0;
    int m_stall = 0, m_flush = 0, m_wait = 0;

    function automatic int fwd_model(input logic [4:0] src);
        if (mem_rw && mem_wr != 0 && mem_wr == src) return 2;
        if (wb_rw && wb_wr != 0 && wb_wr == src) return 1;
        return 0;
    endfunction

    function automatic void decide(output bit freeze, output bit flush, output bit bub);
        bit load_use;
        load_use = ex_m2r && ex_wr != 0 && (ex_wr == id_rs || (id_uses_rt && ex_wr == id_rt));
        freeze = memwait;
        flush  = !memwait && (m_pending || pcsrc);
        bub    = !memwait && !m_pending && !pcsrc && load_use;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge CLK or posedge RST) begin
        bit fz, fl, bb;
        if (RST) begin
            m_pending = 0; m_frozen = 0; m_stall = 0; m_flush = 0; m_wait = 0;
        end else begin
            decide(fz, fl, bb);
            if (fz) m_wait++;
            if (fl) m_flush++;
            if (bb) m_stall++;
            m_pending = memwait ? (m_pending | pcsrc) : 1'b0;
            m_frozen  = memwait;
        end
    end

    always @(negedge CLK) begin
        bit fz, fl, bb;
        if (!RST) begin
            decide(fz, fl, bb);
            check("StallF", int'(hz.StallF), int'(fz | bb));
            check("StallD", int'(hz.StallD), int'(fz | bb));
            check("StallE", int'(hz.StallE), int'(fz));
            check("StallM", int'(hz.StallM), int'(fz));
            check("FlushD", int'(hz.FlushD), int'(fl));
            check("FlushE", int'(hz.FlushE), int'(fl | bb));
            check("FlushM", int'(hz.FlushM), int'(fl));
            check("ForwardAE", int'(hz.ForwardAE), fwd_model(ex_rs));
            check("ForwardBE", int'(hz.ForwardBE), fwd_model(ex_rt));
            check("State", int'(hz.State), m_frozen ? (m_pending ? 2 : 1) : 0);
            check("StallCnt", int'(hz.StallCnt), m_stall);
            check("FlushCnt", int'(hz.FlushCnt), m_flush);
            check("WaitCnt", int'(hz.WaitCnt), m_wait);
            check("StallCnt_w2", int'(hz2.StallCnt), sat(m_stall, 3));
            check("FlushCnt_w2", int'(hz2.FlushCnt), sat(m_flush, 3));
            check("WaitCnt_w2", int'(hz2.WaitCnt), sat(m_wait, 3));
        end
    end

    task automatic set_idle();
        id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0; ex_m2r = 0; ex_wr = 0;
        mem_rw = 0; mem_wr = 0; wb_rw = 0; wb_wr = 0; pcsrc = 0; memwait = 0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
        set_idle();
    endtask

    task automatic settle();
        @(negedge CLK);
    endtask

    initial begin
        // reset with hazards present on the inputs: everything must stay quiet
        ex_rs = 5; mem_rw = 1; mem_wr = 5; memwait = 1; pcsrc = 1;
        #22;
        check("rst_ForwardAE", int'(hz.ForwardAE), 0);
        check("rst_StallF", int'(hz.StallF), 0);
        check("rst_FlushD", int'(hz.FlushD), 0);
        check("rst_State", int'(hz.State), 0);
        check("rst_StallCnt", int'(hz.StallCnt), 0);
        set_idle();
        #1 RST = 1'b0;

        // lw $2 in EX, add $3,$2,$4 in ID
        next_cycle(); ex_m2r = 1; ex_wr = 2; id_rs = 2; id_rt = 4; id_uses_rt = 1; settle();
        check("lu_StallF", int'(hz.StallF), 1);
        check("lu_StallD", int'(hz.StallD), 1);
        check("lu_FlushE", int'(hz.FlushE), 1);
        check("lu_StallE", int'(hz.StallE), 0);
        next_cycle(); mem_rw = 1; mem_wr = 2; id_rs = 2; id_rt = 4; id_uses_rt = 1; settle();
        check("bubble_StallF", int'(hz.StallF), 0);
        check("lu_StallCnt", int'(hz.StallCnt), 1);
        next_cycle(); ex_rs = 2; ex_rt = 4; wb_rw = 1; wb_wr = 2; settle();
        check("lu_wb_fwd", int'(hz.ForwardAE), 1);

        // forwarding priority and register zero
        next_cycle(); ex_rs = 5; mem_rw = 1; mem_wr = 5; wb_rw = 1; wb_wr = 5; settle();
        check("fwd_mem_prio", int'(hz.ForwardAE), 2);
        next_cycle(); ex_rs = 5; mem_rw = 1; mem_wr = 0; wb_rw = 1; wb_wr = 5; settle();
        check("fwd_wb", int'(hz.ForwardAE), 1);
        next_cycle(); ex_rs = 0; ex_rt = 0; mem_rw = 1; wb_rw = 1; settle();
        check("fwd_zero_A", int'(hz.ForwardAE), 0);
        check("fwd_zero_B", int'(hz.ForwardBE), 0);
        next_cycle(); ex_rt = 7; mem_wr = 7; wb_rw = 1; wb_wr = 7; settle();
        check("fwd_B_wb", int'(hz.ForwardBE), 1);

        // taken branch in RUN
        next_cycle(); pcsrc = 1; settle();
        check("br_FlushD", int'(hz.FlushD), 1);
        check("br_FlushM", int'(hz.FlushM), 1);
        check("br_StallF", int'(hz.StallF), 0);
        next_cycle(); settle();
        check("br_FlushCnt", int'(hz.FlushCnt), 1);
        check("br_after_FlushD", int'(hz.FlushD), 0);

        // branch taken while memory busy for three cycles
        next_cycle(); memwait = 1; pcsrc = 1; settle();
        check("mw_StallM", int'(hz.StallM), 1);
        check("mw_FlushD", int'(hz.FlushD), 0);
        next_cycle(); memwait = 1; settle();
        check("mw_State", int'(hz.State), 2);
        next_cycle(); memwait = 1; settle();
        next_cycle(); settle();
        check("mw_release_FlushE", int'(hz.FlushE), 1);
        check("mw_release_StallF", int'(hz.StallF), 0);
        check("mw_WaitCnt", int'(hz.WaitCnt), 3);
        next_cycle(); settle();
        check("mw_FlushCnt", int'(hz.FlushCnt), 2);
        check("mw_State_run", int'(hz.State), 0);
        check("mw_no_double", int'(hz.FlushD), 0);

        // load-use collides with branch, then with memory freeze
        next_cycle(); ex_m2r = 1; ex_wr = 3; id_rs = 3; pcsrc = 1; settle();
        check("lu_br_FlushD", int'(hz.FlushD), 1);
        check("lu_br_StallD", int'(hz.StallD), 0);
        next_cycle(); ex_m2r = 1; ex_wr = 3; id_rt = 3; id_uses_rt = 1; memwait = 1; settle();
        check("lu_mw_StallE", int'(hz.StallE), 1);
        check("lu_mw_FlushE", int'(hz.FlushE), 0);
        next_cycle(); settle();
        check("lu_mw_StallCnt", int'(hz.StallCnt), 1);
        check("lu_mw_State", int'(hz.State), 1);
        check("lu_mw_WaitCnt", int'(hz.WaitCnt), 4);

        // WAIT -> FLUSH_PEND, then reset discards the pending flush
        next_cycle(); memwait = 1; settle();
        next_cycle(); memwait = 1; pcsrc = 1; settle();
        next_cycle(); memwait = 1; settle();
        check("fp_State", int'(hz.State), 2);
        @(posedge CLK);
        #1 RST = 1'b1;
        #1;
        check("fp_rst_State", int'(hz.State), 0);
        check("fp_rst_StallF", int'(hz.StallF), 0);
        check("fp_rst_FlushCnt", int'(hz.FlushCnt), 0);
        check("fp_rst_WaitCnt", int'(hz.WaitCnt), 0);
        set_idle();
        #1 RST = 1'b0;
        next_cycle(); settle();
        check("fp_after_FlushD", int'(hz.FlushD), 0);
        next_cycle(); settle();
        check("fp_after_FlushCnt", int'(hz.FlushCnt), 0);

        // saturation of the narrow counters
        for (int i = 0; i < 5; i++) begin
            next_cycle(); ex_m2r = 1; ex_wr = 9; id_rs = 9; settle();
        end
        next_cycle(); settle();
        check("sat_StallCnt_w16", int'(hz.StallCnt), 5);
        check("sat_StallCnt_w2", int'(hz2.StallCnt), 3);

        next_cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core.
- Drives the stall, flush and forward selects for the IF/ID, ID/EX and EX/MEM pipeline registers. This covers load-use bubbles, taken-branch flushes resolved in MEM, and whole-pipe freezes while data memory is busy.
- Keeps a small state machine for deferred flushes and saturating event counters for debug.

Parameters:
- CNT_W, 16, width of each saturating event counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ID_Rs  in  5  Rs field of instruction in ID.
- ID_Rt  in  5  Rt field of instruction in ID.
- ID_UsesRt  in  1  ID instruction reads Rt (R-type, beq, sw).
- EX_Rs  in  5  Rs held in ID/EX.
- EX_Rt  in  5  Rt held in ID/EX.
- EX_MemtoReg  in  1  ID/EX holds a load.
- EX_WriteReg  in  5  destination register of the EX instruction.
- MEM_RegWrite  in  1  EX/MEM writes the register file.
- MEM_WriteReg  in  5  destination register in EX/MEM.
- WB_RegWrite  in  1  MEM/WB writes the register file.
- WB_WriteReg  in  5  destination register in MEM/WB.
- PCSrcM  in  1  branch taken, resolved in MEM.
- MemWait  in  1  data memory not ready; the whole pipe must hold.
- StallF  out  1  hold PC.
- StallD  out  1  hold IF/ID.
- StallE  out  1  hold ID/EX.
- StallM  out  1  hold EX/MEM.
- FlushD  out  1  clear IF/ID.
- FlushE  out  1  clear ID/EX (bubble).
- FlushM  out  1  clear EX/MEM.
- ForwardAE  out  2  ALU A select: 00 = RD1, 01 = WB result, 10 = MEM ALU result.
- ForwardBE  out  2  same encoding for ALU B.
- State  out  2  FSM state, visible for debug.
- StallCnt  out  CNT_W  load-use bubbles inserted.
- FlushCnt  out  CNT_W  branch flushes performed.
- WaitCnt  out  CNT_W  cycles frozen by MemWait.

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous and active-high. While RST is high: State = RUN, all counters = 0, all Stall/Flush outputs = 0, Forward outputs = 00.
- Register 0 is never a hazard source or forward source; any match against register 0 is ignored.
- Forwarding is combinational, zero latency:
  - ForwardAE = 10 if MEM_RegWrite and MEM_WriteReg == EX_Rs.
  - Otherwise 01 if WB_RegWrite and WB_WriteReg == EX_Rs.
  - Otherwise 00.
  - MEM has priority over WB when both match.
  - ForwardBE uses the same rules with EX_Rt.
- Load-use detect: lu = EX_MemtoReg and EX_WriteReg != 0 and (EX_WriteReg == ID_Rs, or (ID_UsesRt and EX_WriteReg == ID_Rt)).
- FSM states: RUN = 0, WAIT = 1, FLUSH_PEND = 2. Code 3 is illegal and returns to RUN on the next edge with all outputs 0.
- RUN state, with priority MemWait > PCSrcM > lu:
  - MemWait: StallF/D/E/M = 1, no flushes. Next state = FLUSH_PEND if PCSrcM, else WAIT.
  - PCSrcM: FlushD = FlushE = FlushM = 1, stalls 0. FlushCnt++ at the edge.
  - lu: StallF = StallD = 1, FlushE = 1. StallCnt++ at the edge. A load-use stall lasts exactly one cycle: the bubble clears the hazard.
  - Otherwise: all controls 0.
- WAIT state:
  - All four stalls = 1, no flushes, WaitCnt++ every cycle.
  - If PCSrcM is seen while in WAIT: next state = FLUSH_PEND.
  - If MemWait drops: next state = RUN, and this cycle's outputs are evaluated as in RUN.
- FLUSH_PEND state:
  - While MemWait is high: stall all, WaitCnt++.
  - On the first cycle with MemWait low: assert FlushD/E/M, FlushCnt++ once, next state = RUN.
  - A flush is never dropped or doubled, even if PCSrcM has deasserted by then.
- Stall and flush on the same register: flush wins. The controller never asserts both for one register except FlushE with StallD during load-use, which is the intended pairing.
- Counters saturate at all-ones and never wrap.
- RST mid-wait or mid-flush-pending discards the pending flush and returns to RUN immediately.

Decomposition:
- Shared package holds:
  - FSM state encodings RUN, WAIT, FLUSH_PEND.
  - Forward select encodings FWD_RD, FWD_WB, FWD_MEM.
  - The REG_ZERO constant.
- One natural sub-module: sat_counter (width parameter, inc, async RST), instanced three times.
- Forward mux logic stays inline.

Test Plan:
- lw $2 in EX, ID add $3,$2,$4 (ID_Rs = 2) -> one cycle of StallF = StallD = FlushE = 1. Next cycle WB forward gives ForwardAE = 01. StallCnt = 1.
- EX_Rs = 5 with MEM_WriteReg = 5 and WB_WriteReg = 5, both RegWrite -> ForwardAE = 10. With MEM_WriteReg = 0 as well -> ForwardAE = 01. With both write registers 0 -> 00.
- PCSrcM pulse in RUN -> FlushD/E/M = 1 for exactly that cycle, no stalls, FlushCnt = 1.
- MemWait high 3 cycles with PCSrcM high in the first -> stalls for 3 cycles, WaitCnt = 3. In the cycle MemWait falls, a single flush pulse, FlushCnt = 1, then State = RUN.
- lu and PCSrcM in the same cycle -> flush only, StallCnt unchanged. lu with MemWait -> freeze only.
- RST asserted while State = FLUSH_PEND -> outputs and counters 0 immediately; after release no flush occurs. Counters with CNT_W = 2 saturate at 3.
